tc_sample_scheduler: RTL and testbench
======================================

# tc_sample_scheduler

Sequencer for the thermocouple acquisition path. It paces ADC conversions at a programmable period and oversamples 1/2/4/8 ADC codes per burst. It hands the truncated mean code to the temperature calculator and watches for a stalled ADC read with a timeout. It sits between the top-level enable and the ADC SPI master / `tc_calc` pair, replacing the free-running read/calc loop.

## Interface
- `CODE_W`, 10, ADC code width.
- `INTERVAL_W`, 16, width of the period programming input.
- `TIMEOUT`, 64, clock cycles allowed between `o_adc_start` and `i_adc_stb`.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_ena`  in  1  run enable.
- `i_interval`  in  `INTERVAL_W`  burst start-to-start period in cycles.
- `i_avg_log2`  in  2  log2 of samples per burst (0..3).
- `i_fault_clr`  in  1  one-cycle pulse; clears `o_fault`.
- `o_adc_start`  out  1  one-cycle pulse; starts one ADC SPI read.
- `i_adc_stb`  in  1  one-cycle pulse; `i_adc_code` valid.
- `i_adc_code`  in  `CODE_W`  ADC result.
- `o_calc_start`  out  1  one-cycle pulse to calculator.
- `o_calc_code`  out  `CODE_W`  averaged code; registered, held until the next `o_calc_start`.
- `i_calc_done`  in  1  one-cycle pulse from calculator.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_fault`  out  1  sticky ADC timeout flag.
- `o_sample_cnt`  out  8  completed-burst counter; wraps 255→0.

## Operation
- States: IDLE, START, READ, CALC, WAIT.
- **IDLE:**
  - `i_ena`=1 → START.
- **START:**
  - `o_adc_start`=1 for this cycle only. Load the timeout counter with `TIMEOUT`. → READ.
  - On the first START of a burst: latch `i_avg_log2` into `avg_q`, clear the accumulator and sample count `n`, load the period timer with `i_interval`.
- **READ:**
  - The timeout counter decrements each cycle.
  - On `i_adc_stb`: `acc += i_adc_code` (acc width `CODE_W`+3, cannot overflow) and `n++`.
    - If `n` now equals 2^`avg_q`: `o_calc_code <= (acc+code) >> avg_q` (truncating), pulse `o_calc_start`, → CALC.
    - Otherwise → START.
  - Timeout counter reaches 0 with no strobe: set `o_fault`, discard the burst (no `o_calc_start`, `o_sample_cnt` unchanged), → WAIT.
- **CALC:**
  - Wait for `i_calc_done`, then increment `o_sample_cnt` and → WAIT. No timeout in this state.
- **WAIT:**
  - Period timer decrements each cycle, saturating at 0.
  - `i_ena`=0 → IDLE.
  - Timer ≤ 1 → START, which begins a new burst.
- Enable handling:
  - `i_ena` falling mid-burst (START/READ/CALC) does not abort; the burst completes, then WAIT → IDLE.
  - `i_interval` and `i_avg_log2` changes take effect at the next burst start.
- Fault handling:
  - `o_fault` is cleared only by reset or `i_fault_clr`. Set and clear in the same cycle: set wins.

## Timing
- Reset (`rst_n`=0 at an edge) from any state:
  - State → IDLE.
  - All outputs → 0: `o_adc_start`, `o_calc_start`, `o_calc_code`, `o_busy`, `o_fault`, `o_sample_cnt`.
  - Accumulator, counters and `avg_q` cleared. A burst in progress is dropped.
- `i_ena` sampled high in IDLE at edge t → `o_adc_start` high during cycle t+1.
- `i_adc_stb` of the final sample at edge t → `o_calc_start` and new `o_calc_code` during cycle t+1.
- Non-final sample strobe at t → next `o_adc_start` in cycle t+1.
- Strobe in the same cycle the timeout counter reaches 0: the strobe wins, no fault.
- Fault rises in the cycle after the `TIMEOUT`-th READ cycle without a strobe.
- Burst start-to-start spacing is exactly `i_interval` cycles when `i_interval` exceeds the burst length. Otherwise spacing is burst length + 1 (one WAIT cycle minimum).
- Burst length runs from the first `o_adc_start` cycle to the WAIT entry.
- Strobes arriving outside READ, and `i_calc_done` outside CALC, are ignored.

## Test plan
- **Single sample:** `i_avg_log2`=0, ADC returns 0x155 three cycles after start, `i_calc_done` two cycles after `o_calc_start` → exactly one `o_adc_start`, `o_calc_code`=0x155, `o_sample_cnt`=1.
- **Average of 4:** `i_avg_log2`=2, codes 100, 101, 102, 104 → four `o_adc_start` pulses, `o_calc_code`=101 (407>>2).
- **Average of 8 at full scale:** `i_avg_log2`=3, all codes 1023 → `o_calc_code`=1023, no overflow.
- **Period and back-to-back:** `i_interval`=200, `i_avg_log2`=0, fast responders → burst `o_adc_start` edges exactly 200 cycles apart. Then `i_interval`=0 → consecutive bursts separated by exactly one WAIT cycle.
- **Timeout:** no `i_adc_stb` → `o_fault`=1 after 64 READ cycles, no `o_calc_start`, next burst still starts on schedule. `i_fault_clr` → `o_fault`=0. Strobe on the 64th cycle → no fault.
- **Reset and enable:** `rst_n` low mid-READ of a 4-sample burst → all outputs 0, IDLE next cycle, restart begins a fresh burst. `i_ena` dropped mid-burst → burst completes with `o_calc_start` and the count increments, then `o_busy` falls.

Source files
------------

// File: rtl/tc_sample_scheduler.sv
// tc_sample_scheduler
//   Paces thermocouple ADC conversions at a programmable burst period,
//   averages 1/2/4/8 codes per burst and hands the truncated mean to the
//   temperature calculator. A stalled ADC read raises a sticky fault.
//
// Ports
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   i_ena           run enable; a burst in flight always completes
//   i_interval      burst start-to-start period in cycles
//   i_avg_log2      log2 of samples per burst, latched at burst start
//   i_fault_clr     pulse; clears o_fault (a simultaneous set wins)
//   o_adc_start     pulse; starts one ADC SPI read
//   i_adc_stb       pulse; i_adc_code valid (honoured in READ only)
//   i_adc_code      ADC result
//   o_calc_start    pulse to the calculator
//   o_calc_code     averaged code, held until the next o_calc_start
//   i_calc_done     pulse from the calculator (honoured in CALC only)
//   o_busy          high whenever the sequencer is not idle
//   o_fault         sticky ADC read timeout flag
//   o_sample_cnt    completed-burst counter, wraps 255 -> 0
module tc_sample_scheduler #(
   parameter int unsigned CODE_W     = 10,
   parameter int unsigned INTERVAL_W = 16,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_ena,
   input  logic [INTERVAL_W-1:0] i_interval,
   input  logic [1:0]            i_avg_log2,
   input  logic                  i_fault_clr,
   output logic                  o_adc_start,
   input  logic                  i_adc_stb,
   input  logic [CODE_W-1:0]     i_adc_code,
   output logic                  o_calc_start,
   output logic [CODE_W-1:0]     o_calc_code,
   input  logic                  i_calc_done,
   output logic                  o_busy,
   output logic                  o_fault,
   output logic [7:0]            o_sample_cnt
);

   localparam int unsigned ACC_W = CODE_W + 3;
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_READ,
      S_CALC,
      S_WAIT
   } state_t;

   state_t state, state_nxt;

   logic [1:0]            avg_q;
   logic [ACC_W-1:0]      acc;
   logic [3:0]            n;
   logic [INTERVAL_W-1:0] period;
   logic [TO_W-1:0]       to_cnt;
   logic                  burst_first;
   logic                  calc_start_q;
   logic [CODE_W-1:0]     calc_code_q;
   logic                  fault_q;
   logic [7:0]            sample_cnt_q;

   logic [ACC_W-1:0]      acc_sum;
   logic [ACC_W-1:0]      mean;
   logic [3:0]            n_inc;
   logic                  last_sample;
   logic                  timed_out;
   logic [INTERVAL_W-1:0] interval_m1;

   always_comb begin
      acc_sum     = acc + ACC_W'(i_adc_code);
      mean        = acc_sum >> avg_q;
      n_inc       = n + 4'd1;
      last_sample = (n_inc == (4'd1 << avg_q));
      // Counter reaches zero on this cycle's decrement.
      timed_out   = (to_cnt <= TO_W'(1));
      interval_m1 = (i_interval == '0) ? '0 : i_interval - INTERVAL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      o_adc_start = 1'b0;
      o_busy      = (state != S_IDLE);
      case (state)
         S_IDLE:  if (i_ena) state_nxt = S_START;
         S_START: begin
            o_adc_start = 1'b1;
            state_nxt   = S_READ;
         end
         S_READ: begin
            if (i_adc_stb)      state_nxt = last_sample ? S_CALC : S_START;
            else if (timed_out) state_nxt = S_WAIT;
         end
         S_CALC:  if (i_calc_done) state_nxt = S_WAIT;
         S_WAIT: begin
            if (!i_ena)                           state_nxt = S_IDLE;
            else if (period <= INTERVAL_W'(1))    state_nxt = S_START;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         avg_q        <= '0;
         acc          <= '0;
         n            <= '0;
         period       <= '0;
         to_cnt       <= '0;
         burst_first  <= 1'b0;
         calc_start_q <= 1'b0;
         calc_code_q  <= '0;
         fault_q      <= 1'b0;
         sample_cnt_q <= '0;
      end else begin
         calc_start_q <= 1'b0;
         // Period timer runs in every state; it is loaded with interval-1
         // so the WAIT "<= 1" test lands the next start exactly
         // i_interval cycles after the previous one.
         if (period != '0) period <= period - INTERVAL_W'(1);
         if (i_fault_clr) fault_q <= 1'b0;
         case (state)
            S_IDLE, S_WAIT: burst_first <= 1'b1;
            S_START: begin
               burst_first <= 1'b0;
               to_cnt      <= TO_W'(TIMEOUT);
               if (burst_first) begin
                  avg_q  <= i_avg_log2;
                  acc    <= '0;
                  n      <= '0;
                  period <= interval_m1;
               end
            end
            S_READ: begin
               if (to_cnt != '0) to_cnt <= to_cnt - TO_W'(1);
               if (i_adc_stb) begin
                  acc <= acc_sum;
                  n   <= n_inc;
                  if (last_sample) begin
                     calc_code_q  <= mean[CODE_W-1:0];
                     calc_start_q <= 1'b1;
                  end
               end else if (timed_out) begin
                  fault_q <= 1'b1;
               end
            end
            S_CALC: if (i_calc_done) sample_cnt_q <= sample_cnt_q + 8'd1;
            default: ;
         endcase
      end
   end

   assign o_calc_start = calc_start_q;
   assign o_calc_code  = calc_code_q;
   assign o_fault      = fault_q;
   assign o_sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_tc_sample_scheduler.sv
`timescale 1ns/1ps
module tb_tc_sample_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_ena = 1'b0;
   logic [15:0] i_interval = 16'd1000;
   logic [1:0]  i_avg_log2 = 2'd0;
   logic        i_fault_clr = 1'b0;
   logic        o_adc_start;
   logic        i_adc_stb = 1'b0;
   logic [9:0]  i_adc_code = '0;
   logic        o_calc_start;
   logic [9:0]  o_calc_code;
   logic        i_calc_done = 1'b0;
   logic        o_busy;
   logic        o_fault;
   logic [7:0]  o_sample_cnt;

   tc_sample_scheduler #(
      .CODE_W(10),
      .INTERVAL_W(16),
      .TIMEOUT(64)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_ena(i_ena),
      .i_interval(i_interval),
      .i_avg_log2(i_avg_log2),
      .i_fault_clr(i_fault_clr),
      .o_adc_start(o_adc_start),
      .i_adc_stb(i_adc_stb),
      .i_adc_code(i_adc_code),
      .o_calc_start(o_calc_start),
      .o_calc_code(o_calc_code),
      .i_calc_done(i_calc_done),
      .o_busy(o_busy),
      .o_fault(o_fault),
      .o_sample_cnt(o_sample_cnt)
   );

   initial forever #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int adc_starts = 0;

   logic [9:0] adc_q[$];
   logic [9:0] exp_q[$];
   bit         adc_respond = 1'b1;
   int         adc_delay = 1;
   int         calc_delay = 1;
   int         adc_cd = 0;
   int         calc_cd = 0;
   logic [9:0] adc_pending = '0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever @(posedge clk) cyc++;

   // ADC model: strobe arrives adc_delay cycles after the start pulse.
   initial forever begin
      @(negedge clk);
      i_adc_stb = 1'b0;
      if (adc_cd > 0) begin
         adc_cd--;
         if (adc_cd == 0) begin
            i_adc_stb  = 1'b1;
            i_adc_code = adc_pending;
         end
      end
      if (o_adc_start && adc_respond) begin
         adc_cd      = adc_delay;
         adc_pending = (adc_q.size() > 0) ? adc_q.pop_front() : 10'd0;
      end
   end

   // Calculator model: done arrives calc_delay cycles after calc_start.
   initial forever begin
      @(negedge clk);
      i_calc_done = 1'b0;
      if (calc_cd > 0) begin
         calc_cd--;
         if (calc_cd == 0) i_calc_done = 1'b1;
      end
      if (o_calc_start) calc_cd = calc_delay;
   end

   // Scoreboard monitor.
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (o_adc_start) adc_starts++;
         if (o_calc_start) begin
            check("calc_start_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("calc_code", o_calc_code, e);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic wait_start(input int max, output int c);
      c = -1;
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         if (o_adc_start) begin
            c = cyc;
            break;
         end
      end
      check("adc_start_seen", c >= 0, 1);
   endtask

   task automatic wait_idle(input int max);
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         if (!o_busy) break;
      end
      check("idle_reached", o_busy, 0);
   endtask

   task automatic one_burst(input logic [1:0] avg, input int d, input int cd,
                            input logic [9:0] exp, input int nstarts,
                            input int cnt_exp, input string tag);
      int st0;
      i_avg_log2 = avg;
      adc_delay  = d;
      calc_delay = cd;
      exp_q.push_back(exp);
      st0 = adc_starts;
      @(negedge clk);
      i_ena = 1'b1;
      @(negedge clk);
      i_ena = 1'b0;
      wait_idle(2000);
      check({tag, "_starts"}, adc_starts - st0, nstarts);
      check({tag, "_cnt"}, o_sample_cnt, cnt_exp);
      check({tag, "_code_held"}, o_calc_code, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_adc_start"}, o_adc_start, 0);
      check({tag, "_calc_start"}, o_calc_start, 0);
      check({tag, "_calc_code"}, o_calc_code, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_fault"}, o_fault, 0);
      check({tag, "_sample_cnt"}, o_sample_cnt, 0);
   endtask

   initial begin
      int s0, s1, s2;
      int cnt0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single sample, 0x155 after 3 cycles, done 2 cycles after calc_start.
      i_interval = 16'd1000;
      adc_q.push_back(10'h155);
      one_burst(2'd0, 3, 2, 10'h155, 1, 1, "single");

      // Average of 4: 407 >> 2 = 101.
      adc_q.push_back(10'd100); adc_q.push_back(10'd101);
      adc_q.push_back(10'd102); adc_q.push_back(10'd104);
      one_burst(2'd2, 2, 1, 10'd101, 4, 2, "avg4");

      // Average of 8 at full scale.
      for (int k = 0; k < 8; k++) adc_q.push_back(10'd1023);
      one_burst(2'd3, 1, 1, 10'd1023, 8, 3, "avg8_full");

      // Average of 2 truncates: 7 >> 1 = 3.
      adc_q.push_back(10'd3); adc_q.push_back(10'd4);
      one_burst(2'd1, 1, 3, 10'd3, 2, 4, "avg2_trunc");

      // Programmed period of 200 cycles.
      i_interval = 16'd200; i_avg_log2 = 2'd0; adc_delay = 1; calc_delay = 1;
      adc_q.push_back(10'd10); adc_q.push_back(10'd20); adc_q.push_back(10'd30);
      exp_q.push_back(10'd10); exp_q.push_back(10'd20); exp_q.push_back(10'd30);
      @(negedge clk); i_ena = 1'b1;
      wait_start(50, s0);
      wait_start(300, s1);
      wait_start(300, s2);
      i_ena = 1'b0;
      check("period_gap1", s1 - s0, 200);
      check("period_gap2", s2 - s1, 200);
      wait_idle(300);
      check("period_cnt", o_sample_cnt, 7);

      // Back-to-back: burst of 4 cycles plus one WAIT cycle.
      i_interval = 16'd0;
      adc_q.push_back(10'd1); adc_q.push_back(10'd2); adc_q.push_back(10'd3);
      exp_q.push_back(10'd1); exp_q.push_back(10'd2); exp_q.push_back(10'd3);
      @(negedge clk); i_ena = 1'b1;
      wait_start(50, s0);
      wait_start(50, s1);
      wait_start(50, s2);
      i_ena = 1'b0;
      check("b2b_gap1", s1 - s0, 5);
      check("b2b_gap2", s2 - s1, 5);
      wait_idle(100);
      check("b2b_cnt", o_sample_cnt, 10);

      // Timeout: no strobe.
      i_interval = 16'd200; adc_respond = 1'b0; cnt0 = o_sample_cnt;
      @(negedge clk); i_ena = 1'b1;
      wait_start(50, s0);
      repeat (64) @(negedge clk);
      check("fault_before_timeout", o_fault, 0);
      @(negedge clk);
      check("fault_set", o_fault, 1);
      check("fault_burst_ends", o_busy, 1);
      i_fault_clr = 1'b1;
      @(negedge clk);
      i_fault_clr = 1'b0;
      check("fault_clr", o_fault, 0);
      wait_start(300, s1);
      check("timeout_next_on_schedule", s1 - s0, 200);
      i_ena = 1'b0;
      repeat (64) @(negedge clk);
      i_fault_clr = 1'b1;
      @(negedge clk);
      i_fault_clr = 1'b0;
      check("fault_set_wins", o_fault, 1);
      wait_idle(300);
      check("timeout_cnt_unchanged", o_sample_cnt, cnt0);
      @(negedge clk); i_fault_clr = 1'b1;
      @(negedge clk); i_fault_clr = 1'b0;
      check("fault_clr_idle", o_fault, 0);
      adc_respond = 1'b1;

      // Strobe on the 64th READ cycle wins over the timeout.
      adc_q.push_back(10'h2AA);
      one_burst(2'd0, 64, 1, 10'h2AA, 1, 11, "stb_at_64");
      check("stb_at_64_no_fault", o_fault, 0);

      // Reset in the READ of the second sample of a 4-sample burst.
      i_avg_log2 = 2'd2; adc_delay = 1; calc_delay = 1;
      adc_q.push_back(10'd50); adc_q.push_back(10'd60);
      @(negedge clk); i_ena = 1'b1;
      wait_start(50, s0);
      i_ena = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_busy", o_busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("rst_mid");
      rst_n = 1'b1;
      adc_q.push_back(10'd8); adc_q.push_back(10'd8);
      adc_q.push_back(10'd8); adc_q.push_back(10'd12);
      one_burst(2'd2, 1, 1, 10'd9, 4, 1, "fresh");

      repeat (5) @(negedge clk);
      check("exp_queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
